// File: rtl/usb_rx_destuffer.sv
`default_nettype none
// ============================================================================
// usb_rx_destuffer : NRZI decoder and USB bit-stuff remover feeding the CRC.
//                    Define USB_RX_BITCNT_EN to add the bit_count output.
// Revision 1.0
// ============================================================================
module usb_rx_destuffer #(
  parameter int MAX_RUN = 6
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        bit_strobe,
  input  logic        line_in,
  input  logic        rx_active,
  output logic        shift_enable,
  output logic        serial_in,
  output logic        stuff_err
`ifdef USB_RX_BITCNT_EN
  ,
  output logic [10:0] bit_count
`endif
);

  localparam int                 c_cnt_w   = $clog2(MAX_RUN + 1);
  localparam logic [c_cnt_w-1:0] c_max_run = c_cnt_w'(MAX_RUN);

  logic               r_prev_level;
  logic               r_rx_active_q;
  logic               r_armed;
  logic [c_cnt_w-1:0] r_run_cnt;

  logic               w_decoded;
  logic               w_rise;
  logic               w_take;
  logic [c_cnt_w-1:0] w_run_eff;
  logic               w_stuffed;
  logic               w_deliver;
  logic               w_err_eff;

  // A rise clears per-packet state in the same cycle, so a coincident strobe
  // is judged against the cleared values.
  assign w_decoded = (line_in == r_prev_level);
  assign w_rise    = rx_active & ~r_rx_active_q;
  assign w_take    = bit_strobe & rx_active & (r_armed | w_rise);
  assign w_run_eff = w_rise ? '0 : r_run_cnt;
  assign w_stuffed = (w_run_eff == c_max_run);
  assign w_deliver = w_take & ~w_stuffed;
  assign w_err_eff = w_rise ? 1'b0 : stuff_err;

  // r_rx_active_q resets high so a packet only starts on a genuine rise.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_prev_level  <= 1'b1;
      r_rx_active_q <= 1'b1;
      r_armed       <= 1'b0;
      r_run_cnt     <= '0;
      shift_enable  <= 1'b0;
      serial_in     <= 1'b0;
      stuff_err     <= 1'b0;
    end else begin
      if (bit_strobe) begin
        r_prev_level <= line_in;
      end
      r_rx_active_q <= rx_active;
      r_armed       <= rx_active & (r_armed | w_rise);
      shift_enable  <= w_deliver;
      if (w_deliver) begin
        serial_in <= w_decoded;
      end
      if (!rx_active) begin
        r_run_cnt <= '0;
      end else if (w_take) begin
        r_run_cnt <= (w_stuffed | ~w_decoded) ? '0 : w_run_eff + c_cnt_w'(1);
      end else begin
        r_run_cnt <= w_run_eff;
      end
      stuff_err <= w_err_eff | (w_take & w_stuffed & w_decoded);
    end
  end

`ifdef USB_RX_BITCNT_EN
  logic [10:0] w_count_base;

  assign w_count_base = w_rise ? '0 : bit_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_count <= '0;
    end else if (w_deliver && (w_count_base != 11'h7FF)) begin
      bit_count <= w_count_base + 11'd1;
    end else begin
      bit_count <= w_count_base;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_destuffer.sv
`default_nettype none
// tb_usb_rx_destuffer : table vectors, hand-written corner sequences and a
// randomized run against a queue-based reference model.
module tb_usb_rx_destuffer;

  localparam int MAX_RUN = 6;

  logic clk        = 1'b0;
  logic n_rst      = 1'b0;
  logic bit_strobe = 1'b0;
  logic line_in    = 1'b1;
  logic rx_active  = 1'b0;
  logic shift_enable;
  logic serial_in;
  logic stuff_err;
`ifdef USB_RX_BITCNT_EN
  logic [10:0] bit_count;
`endif

  int   errors = 0;
  int   checks = 0;
  logic tb_line = 1'b1;

  usb_rx_destuffer #(.MAX_RUN(MAX_RUN)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .bit_strobe   (bit_strobe),
    .line_in      (line_in),
    .rx_active    (rx_active),
    .shift_enable (shift_enable),
    .serial_in    (serial_in),
    .stuff_err    (stuff_err)
`ifdef USB_RX_BITCNT_EN
    ,
    .bit_count    (bit_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic s;
    logic d;
    logic a;
    logic se;
    logic si;
    logic err;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: delivered bits since the last stuffed bit.
  logic m_prev, m_last_a, m_armed, m_err, m_se, m_si;
  bit   m_q[$];

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic d, input logic a,
                     input logic se, input logic si, input logic err);
    vecs.push_back('{s, d, a, se, si, err});
  endtask

  task automatic drive_lvl(input logic s, input logic l, input logic a);
    @(negedge clk);
    bit_strobe = s;
    line_in    = l;
    rx_active  = a;
    tb_line    = l;
    @(posedge clk);
    #1;
  endtask

  // d is the wanted decoded bit: 1 keeps the line level, 0 toggles it.
  task automatic drive_dec(input logic s, input logic d, input logic a);
    logic l;
    l = s ? (d ? tb_line : ~tb_line) : tb_line;
    drive_lvl(s, l, a);
  endtask

  task automatic model_reset();
    m_prev   = 1'b1;
    m_last_a = 1'b1;
    m_armed  = 1'b0;
    m_err    = 1'b0;
    m_se     = 1'b0;
    m_si     = 1'b0;
    m_q.delete();
  endtask

  function automatic bit next_is_stuffed();
    if (m_q.size() < MAX_RUN) return 1'b0;
    foreach (m_q[k]) if (!m_q[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input logic s, input logic l, input logic a);
    logic d;
    bit   rise;
    rise = a && !m_last_a;
    m_se = 1'b0;
    if (!a) begin
      m_armed = 1'b0;
      m_q.delete();
    end else if (rise) begin
      m_armed = 1'b1;
      m_err   = 1'b0;
      m_q.delete();
    end
    if (s && a && m_armed) begin
      d = (l == m_prev);
      if (next_is_stuffed()) begin
        if (d) m_err = 1'b1;
        m_q.delete();
      end else begin
        m_se = 1'b1;
        m_si = d;
        m_q.push_back(d);
        if (m_q.size() > MAX_RUN) void'(m_q.pop_front());
      end
    end
    if (s) m_prev = l;
    m_last_a = a;
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst      = 1'b0;
    bit_strobe = 1'b0;
    rx_active  = 1'b0;
    line_in    = 1'b1;
    tb_line    = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    drive_lvl(1'b0, 1'b1, 1'b0);
    model_step(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [31:0] word;
    logic [31:0] got;
    bit          dq[$];
    bit          stf[$];
    int          ones;
    int          npulse;
    logic        l, a, s;

    do_reset();
    check("reset shift_enable", shift_enable, 1'b0);
    check("reset serial_in", serial_in, 1'b0);
    check("reset stuff_err", stuff_err, 1'b0);

    // Idle, stuffed packet, strobe on fall, violation and sticky error clear.
    for (int i = 0; i < 10; i++) add(1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) add(1, 1, 1, 1, 1, 0);
    add(1, 0, 1, 0, 1, 0);
    for (int i = 0; i < 2; i++) add(1, 1, 1, 1, 1, 0);
    for (int i = 0; i < 8; i++) add(1, 0, 1, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      add(1, 1, 1, 1, 1, 0);
      add(0, 0, 1, 0, 1, 0);
    end
    add(1, 1, 1, 0, 1, 1);
    add(0, 0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 1, 1);
    add(0, 0, 1, 0, 1, 0);

    foreach (vecs[i]) begin
      drive_dec(vecs[i].s, vecs[i].d, vecs[i].a);
      check($sformatf("vec%0d shift_enable", i), shift_enable, vecs[i].se);
      check($sformatf("vec%0d serial_in", i), serial_in, vecs[i].si);
      check($sformatf("vec%0d stuff_err", i), stuff_err, vecs[i].err);
    end

    // CRC word with a stuffed zero inserted after every six ones.
    word = 32'h0302A5FE;
    ones = 0;
    for (int i = 31; i >= 0; i--) begin
      dq.push_back(word[i]);
      stf.push_back(1'b0);
      ones = word[i] ? ones + 1 : 0;
      if (ones == MAX_RUN) begin
        dq.push_back(1'b0);
        stf.push_back(1'b1);
        ones = 0;
      end
    end
    drive_dec(0, 0, 0);
    drive_dec(0, 0, 1);
    got    = '0;
    npulse = 0;
    foreach (dq[k]) begin
      drive_dec(1, dq[k], 1);
      check($sformatf("crc bit%0d pulse", k), shift_enable, !stf[k]);
      if (shift_enable) begin
        got = {got[30:0], serial_in};
        npulse++;
      end
      for (int g = 0; g < 3; g++) begin
        drive_dec(0, 0, 1);
        check("crc gap no pulse", shift_enable, 1'b0);
      end
    end
    check_int("crc pulse count", npulse, 32);
    check_int("crc data word", int'(got), int'(word));
    check("crc stuff_err", stuff_err, 1'b0);

    // Reset mid-packet with a pulse and a sticky error outstanding.
    drive_dec(0, 0, 0);
    drive_dec(0, 0, 1);
    for (int i = 0; i < 7; i++) drive_dec(1, 1, 1);
    for (int i = 0; i < 5; i++) drive_dec(1, 1, 1);
    check("pre-reset shift_enable", shift_enable, 1'b1);
    check("pre-reset stuff_err", stuff_err, 1'b1);
    n_rst   = 1'b0;
    line_in = 1'b1;
    tb_line = 1'b1;
    #1;
    check("async reset shift_enable", shift_enable, 1'b0);
    check("async reset serial_in", serial_in, 1'b0);
    check("async reset stuff_err", stuff_err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_dec(1, 1, 1);
      check("post-reset idle", shift_enable, 1'b0);
    end
    drive_dec(0, 0, 0);
    drive_dec(0, 0, 1);
    drive_dec(1, 0, 1);
    check("restart pulse", shift_enable, 1'b1);
    check("restart data", serial_in, 1'b0);

    // Randomized run; line biased toward long runs of decoded ones.
    do_reset();
    a = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      s = 1'($urandom_range(0, 1));
      l = ($urandom_range(0, 3) == 0) ? ~tb_line : tb_line;
      if ($urandom_range(0, 99) == 0) a = ~a;
      drive_lvl(s, l, a);
      model_step(s, l, a);
      check($sformatf("rnd%0d shift_enable", n), shift_enable, m_se);
      check($sformatf("rnd%0d serial_in", n), serial_in, m_si);
      check($sformatf("rnd%0d stuff_err", n), stuff_err, m_err);
    end

`ifdef USB_RX_BITCNT_EN
    do_reset();
    check_int("bit_count reset", int'(bit_count), 0);
    drive_dec(0, 0, 1);
    for (int i = 1; i <= 2100; i++) begin
      drive_dec(1, 0, 1);
      if (i == 2046) check_int("bit_count 2046", int'(bit_count), 2046);
    end
    check_int("bit_count saturate", int'(bit_count), 2047);
    drive_dec(0, 0, 0);
    drive_dec(0, 0, 1);
    check_int("bit_count clear on rise", int'(bit_count), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
